// File: rtl/rc4_pkg.sv
// Shared constants and FSM encoding for the RC4 keystream/decrypt block.
package rc4_pkg;

    localparam int S_DEPTH     = 256;
    localparam int MAX_MSG_LEN = 32;
    localparam int IDX_W       = $clog2(S_DEPTH);
    localparam int K_W         = $clog2(MAX_MSG_LEN);

    typedef enum logic [3:0] {
        IDLE,
        RD_SI,
        WAIT_SI,
        RD_SJ,
        WAIT_SJ,
        WR_SI,
        WR_SJ,
        RD_F,
        WAIT_F,
        WR_DEC,
        DONE
    } rc4_state_t;

endpackage

// File: rtl/rc4_decrypt.sv
// RC4 PRGA over an externally held, already-shuffled S array: produces MSG_LEN
// keystream bytes, XORs them with the ciphertext ROM and writes the plaintext RAM.
module rc4_decrypt
    import rc4_pkg::*;
#(
    parameter int MSG_LEN = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    output logic             finish,
    output logic [IDX_W-1:0] s_address,
    output logic [7:0]       s_data,
    output logic             s_wren,
    input  logic [7:0]       s_q,
    output logic [K_W-1:0]   rom_address,
    input  logic [7:0]       rom_q,
    output logic [K_W-1:0]   dec_address,
    output logic [7:0]       dec_data,
    output logic             dec_wren
);

    localparam logic [K_W-1:0] LAST_K = K_W'(MSG_LEN - 1);

    rc4_state_t state_reg, state_next;

    logic [IDX_W-1:0] i_reg;
    logic [IDX_W-1:0] j_reg;
    logic [K_W-1:0]   k_reg;
    logic [7:0]       s_i_reg;
    logic [7:0]       s_j_reg;
    logic [7:0]       s_f_reg;
    logic [7:0]       rom_byte_reg;
    logic [IDX_W-1:0] f_index;

    // After the swap S[i]+S[j] equals the pre-swap s_i+s_j, so the latched pair suffices.
    assign f_index = s_i_reg + s_j_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (start) state_next = RD_SI;
            RD_SI:   state_next = WAIT_SI;
            WAIT_SI: state_next = RD_SJ;
            RD_SJ:   state_next = WAIT_SJ;
            WAIT_SJ: state_next = WR_SI;
            WR_SI:   state_next = WR_SJ;
            WR_SJ:   state_next = RD_F;
            RD_F:    state_next = WAIT_F;
            WAIT_F:  state_next = WR_DEC;
            WR_DEC:  state_next = (k_reg == LAST_K) ? DONE : RD_SI;
            DONE:    if (!start) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i_reg        <= '0;
            j_reg        <= '0;
            k_reg        <= '0;
            s_i_reg      <= '0;
            s_j_reg      <= '0;
            s_f_reg      <= '0;
            rom_byte_reg <= '0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    // Every run restarts the PRGA; i is pre-incremented for byte 0.
                    if (start) begin
                        i_reg <= IDX_W'(1);
                        j_reg <= '0;
                        k_reg <= '0;
                    end
                end
                WAIT_SI: begin
                    s_i_reg <= s_q;
                    j_reg   <= j_reg + s_q;
                end
                WAIT_SJ: begin
                    s_j_reg <= s_q;
                end
                WAIT_F: begin
                    s_f_reg      <= s_q;
                    rom_byte_reg <= rom_q;
                end
                WR_DEC: begin
                    if (k_reg != LAST_K) begin
                        k_reg <= k_reg + 1'b1;
                        i_reg <= i_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        finish      = 1'b0;
        s_address   = '0;
        s_data      = '0;
        s_wren      = 1'b0;
        rom_address = '0;
        dec_address = '0;
        dec_data    = '0;
        dec_wren    = 1'b0;
        unique case (state_reg)
            RD_SI, WAIT_SI: s_address = i_reg;
            RD_SJ, WAIT_SJ: s_address = j_reg;
            WR_SI: begin
                s_address = i_reg;
                s_data    = s_j_reg;
                s_wren    = 1'b1;
            end
            WR_SJ: begin
                s_address = j_reg;
                s_data    = s_i_reg;
                s_wren    = 1'b1;
            end
            RD_F, WAIT_F: begin
                s_address   = f_index;
                rom_address = k_reg;
            end
            WR_DEC: begin
                rom_address = k_reg;
                dec_address = k_reg;
                dec_data    = s_f_reg ^ rom_byte_reg;
                dec_wren    = 1'b1;
            end
            DONE:    finish = 1'b1;
            default: ;
        endcase
    end

endmodule
